// File: rtl/spi_read_arbiter.sv
// rtl/spi_read_arbiter.sv - two-port arbiter and sequencer for the shared spi_flash_read engine
module spi_read_arbiter #(
  parameter int unsigned        TMO_W        = 24,
  parameter int unsigned        ACK_TIMEOUT  = 16,
  parameter logic [TMO_W-1:0]   DONE_TIMEOUT = 24'hFFFFFF
) (
  input  logic        system_clk,
  input  logic        system_reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] start_addr0,
  input  logic [31:0] start_addr1,
  input  logic [31:0] end_addr0,
  input  logic [31:0] end_addr1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  input  logic        die0,
  input  logic        die1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        eng_start_flag,
  output logic        eng_read_req,
  output logic [31:0] eng_start_addr,
  output logic [31:0] eng_end_addr,
  output logic [1:0]  eng_mode,
  output logic        eng_switch_die_need,
  input  logic        eng_read_finish,
  output logic        busy,
  output logic        owner
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_LAUNCH    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  // Timeouts fire on the cycle the counter would reach the limit, so the
  // error pulse lands exactly TIMEOUT cycles after the wait state is entered.
  localparam logic [TMO_W-1:0] ACK_LAST    = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] DONE_LAST   = DONE_TIMEOUT - TMO_W'(1);
  localparam bit               DONE_TMO_EN = (DONE_TIMEOUT != '0);
  localparam logic [TMO_W-1:0] CNT_MAX     = {TMO_W{1'b1}};

  logic [2:0]       state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err0_q, err0_d;
  logic             err1_q, err1_d;
  logic             start_flag_q, start_flag_d;
  logic             read_req_q, read_req_d;
  logic [31:0]      start_addr_q, start_addr_d;
  logic [31:0]      end_addr_q, end_addr_d;
  logic [1:0]       mode_q, mode_d;
  logic             die_q, die_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic             sel;
  logic             bad_req;
  logic             finish_ok;
  logic             finish_err;

  // Request validation uses the latched copy so it cannot race a requester
  // that changes its inputs after the grant.
  assign bad_req = (end_addr_q < start_addr_q) || (mode_q == 2'b11);

  // Next-state and next-output computation; every output is a register.
  always_comb begin
    state_d      = state_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    start_flag_d = 1'b0;
    read_req_d   = read_req_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    mode_d       = mode_q;
    die_d        = die_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    sel          = 1'b0;
    finish_ok    = 1'b0;
    finish_err   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Alone, a requester wins outright; together, rr_q names the port
          // that did not finish last.
          sel          = (req0 && req1) ? rr_q : req1;
          owner_d      = sel;
          gnt0_d       = ~sel;
          gnt1_d       = sel;
          start_addr_d = sel ? start_addr1 : start_addr0;
          end_addr_d   = sel ? end_addr1   : end_addr0;
          mode_d       = sel ? mode1       : mode0;
          die_d        = sel ? die1        : die0;
          state_d      = S_CHECK;
        end
      end

      S_CHECK: begin
        if (bad_req) begin
          finish_err = 1'b1;
          state_d    = S_ERR;
        end else begin
          start_flag_d = 1'b1;
          read_req_d   = 1'b1;
          state_d      = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (!eng_read_finish) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == ACK_LAST) begin
          finish_err = 1'b1;
          state_d    = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (eng_read_finish) begin
          finish_ok = 1'b1;
          state_d   = S_DONE;
        end else if (DONE_TMO_EN && (cnt_q == DONE_LAST)) begin
          finish_err = 1'b1;
          state_d    = S_ERR;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_ERR: begin
        // Release the engine and hand priority to the other port.
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        read_req_d = 1'b0;
        rr_d       = ~owner_q;
        state_d    = S_IDLE;
      end

      default: begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        read_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    // Completion pulses are raised on entry to DONE/ERR for the owning port.
    done0_d = (finish_ok || finish_err) && !owner_q;
    done1_d = (finish_ok || finish_err) &&  owner_q;
    err0_d  = finish_err && !owner_q;
    err1_d  = finish_err &&  owner_q;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset drops the engine request at once.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= S_IDLE;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      start_flag_q <= 1'b0;
      read_req_q   <= 1'b0;
      start_addr_q <= 32'h0;
      end_addr_q   <= 32'h0;
      mode_q       <= 2'b00;
      die_q        <= 1'b0;
      busy_q       <= 1'b0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      start_flag_q <= start_flag_d;
      read_req_q   <= read_req_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      mode_q       <= mode_d;
      die_q        <= die_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign gnt0                = gnt0_q;
  assign gnt1                = gnt1_q;
  assign done0               = done0_q;
  assign done1               = done1_q;
  assign err0                = err0_q;
  assign err1                = err1_q;
  assign eng_start_flag      = start_flag_q;
  assign eng_read_req        = read_req_q;
  assign eng_start_addr      = start_addr_q;
  assign eng_end_addr        = end_addr_q;
  assign eng_mode            = mode_q;
  assign eng_switch_die_need = die_q;
  assign busy                = busy_q;
  assign owner               = owner_q;

endmodule

// File: doc/spi_read_arbiter.md
Name: spi_read_arbiter

Overview:
- Sequences and shares the single spi_flash_read engine between two requesters (port 0: BMC-side image copy, port 1: PCH-side image copy).
- Latches a requester's address window, mode and die-switch flag, launches the engine, and tracks its read_finish level. Reports done or error per requester.
- Sits between the requesters and spi_flash_read in the system_clk domain, replacing direct top-level driving of start_flag/read_req.

Parameters:
- ACK_TIMEOUT, 16: max cycles from start_flag to eng_read_finish falling before error.
- DONE_TIMEOUT, 24'hFFFFFF: max cycles with eng_read_finish low before error; 0 disables the check.
- TMO_W, 24: timeout counter width. Must hold both timeout values.

Ports:
- system_clk  in  1  system clock; all logic rising-edge.
- system_reset_n  in  1  asynchronous active-low reset.
- req0 / req1  in  1  level request from port 0 / 1.
- start_addr0 / start_addr1  in  32  first byte address.
- end_addr0 / end_addr1  in  32  last byte address (inclusive).
- mode0 / mode1  in  2  read mode; 2'b11 is reserved.
- die0 / die1  in  1  switch_die_need for the request.
- gnt0 / gnt1  out  1  level; the port owns the engine.
- done0 / done1  out  1  one-cycle pulse at end of the serviced request.
- err0 / err1  out  1  one-cycle pulse coincident with done on a failed request.
- eng_start_flag  out  1  one-cycle launch pulse to the engine.
- eng_read_req  out  1  level, held for the whole operation.
- eng_start_addr  out  32  registered start address to the engine.
- eng_end_addr  out  32  registered end address to the engine.
- eng_mode  out  2  registered mode to the engine.
- eng_switch_die_need  out  1  registered die-switch flag to the engine.
- eng_read_finish  in  1  engine level: 1 = idle/finished, 0 = reading.
- busy  out  1  high in every state except IDLE.
- owner  out  1  port currently or last granted.

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; round-robin pointer favours port 0.
- Reset mid-operation drops eng_read_req and gnt immediately. No done is issued.

FSM: IDLE -> CHECK -> LAUNCH -> WAIT_ACK -> WAIT_DONE -> DONE -> IDLE. ERR -> IDLE.
- IDLE:
  - One req high: select that port.
  - Both high: select the port not served last (round-robin).
  - On selection, register that port's addr/mode/die into the eng_* outputs. Set gnt and owner at the same edge, then go to CHECK.
- CHECK (1 cycle):
  - If end_addr < start_addr (unsigned 32-bit) or mode == 2'b11, go to ERR.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): eng_start_flag = 1 and eng_read_req = 1. Go to WAIT_ACK and clear the timeout counter.
- WAIT_ACK:
  - eng_read_req held high.
  - eng_read_finish == 0 goes to WAIT_DONE and clears the counter.
  - Counter reaching ACK_TIMEOUT goes to ERR.
- WAIT_DONE:
  - eng_read_finish == 1 goes to DONE.
  - If DONE_TIMEOUT != 0 and the counter reaches DONE_TIMEOUT, go to ERR.
  - The counter saturates; it never wraps.
- DONE (1 cycle): done<owner> = 1. eng_read_req, gnt and eng_start_flag go 0 at the next edge. Round-robin pointer moves to the other port. Return to IDLE.
- ERR (1 cycle): done<owner> = 1 and err<owner> = 1. eng_read_req and gnt drop at the next edge. Pointer updates as in DONE. Return to IDLE.

Timing and handshake rules:
- Latency: req sampled high at edge N -> gnt high after N. eng_start_flag high in cycle N+2. Minimum done at edge N+4 after the engine responds.
- eng_* address/mode/die outputs are stable from gnt rise until return to IDLE. Requester inputs are ignored while busy.
- req dropped mid-operation: ignored; the operation completes and done still pulses.
- Requesters must drop req on seeing done. A req still high in IDLE is re-arbitrated as a new request, at lower priority if the other port is requesting.
- Single-address window (end == start) is legal.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- Single request: req0 with start=0x1000, end=0x1FFF, mode=2'b01, die0=0; engine model drops finish 3 cycles after start_flag and raises it 100 cycles later -> gnt0 at edge 1, start_flag at cycle 2, eng_* = request values, done0 pulse once, err0 = 0, busy low afterwards.
- Contention: req0 and req1 high simultaneously from reset, both held -> port 0 served first, then port 1. With both still held, a third grant goes to port 0. gnt never overlaps.
- Bad window: req1 with start=0x2000, end=0x1FFF -> done1 and err1 pulse in the cycle after CHECK. No eng_start_flag. eng_read_req stays 0.
- Ack timeout: engine never drops finish, ACK_TIMEOUT=16 -> err pulse 16 cycles after WAIT_ACK entry; eng_read_req deasserted.
- Done timeout: DONE_TIMEOUT=50 with an engine read of 200 cycles -> err at 50. Repeat with DONE_TIMEOUT=0 -> normal done at 200.
- Reset mid-read: assert system_reset_n=0 during WAIT_DONE -> all outputs 0 immediately, no done. After release, a new req0 is served normally.
